soc_system_pio_gp: RTL and testbench
====================================

Name: soc_system_pio_gp

Overview:
- Parametrised Avalon-MM slave general-purpose PIO; successor to the fixed 16-bit output-only colour PIO.
- Adds per-bit direction, input synchronisation, edge capture with interrupt and atomic set/clear of output bits.
- Sits on the HPS lightweight bridge.
- Pins are split into out_port, out_en and in_port; the top level forms tristate buffers from out_port and out_en.

Parameters:
- DATA_WIDTH, 16, number of PIO bits (1..32).
- RESET_VALUE, 0, reset value of the output data register (DATA_WIDTH bits).
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2, flops in the in_port synchroniser (2..4).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  register word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered, read latency 1.
- in_port  in  DATA_WIDTH  asynchronous pin inputs.
- out_port  out  DATA_WIDTH  output data register.
- out_en  out  DATA_WIDTH  per-bit output enable (1 = drive).
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset is clk domain, reset_n asynchronous active-low. Reset values:
  - data_out = RESET_VALUE.
  - dir = 0 (all bits inputs).
  - irq_mask = 0, edge_cap = 0.
  - Synchroniser flops and prev = 0.
  - readdata = 0, irq = 0.
- Write occurs when chipselect & ~write_n; only writedata[DATA_WIDTH-1:0] is used. Register map:
  - addr 0 DATA: write loads data_out. Read returns, per bit, data_out when dir=1, else the synchronised input.
  - addr 1 DIR: read/write; drives out_en.
  - addr 2 IRQ_MASK: read/write.
  - addr 3 EDGE_CAP: read returns edge_cap. Write-1-to-clear; 0 bits unaffected.
  - addr 4 OUTSET: write ORs data_out with writedata. Reads 0.
  - addr 5 OUTCLR: write ANDs data_out with ~writedata. Reads 0.
  - addr 6-7: writes ignored, reads 0.
- Readdata is registered every clock when chipselect & ~read_n from the address mux; upper bits beyond DATA_WIDTH are 0. Otherwise readdata holds its previous value.
- Written values appear on out_port/out_en on the clock edge after the write cycle.
- Input path: in_port → SYNC_STAGES flop chain → sync; prev <= sync each clk.
- Edge detect (on sync/prev):
  - rise = sync & ~prev.
  - fall = ~sync & prev.
  - any = sync ^ prev.
- Edge detect applies to all bits regardless of dir, so output-bit toggles are also captured.
- edge_cap[i] sets when the selected edge is detected. A pin change sampled at edge k is in edge_cap after edge k+SYNC_STAGES.
- Simultaneous W1C and new edge on the same bit: the bit stays 1 (set wins).
- Bits not being set follow the W1C rule.
- irq = |(edge_cap & irq_mask), combinational from registers. It deasserts the cycle after the clearing write, unless set wins.
- Changing irq_mask takes effect on irq the cycle after the write.
- Glitch shorter than one clk may be missed; this is acceptable.
- Reset mid-operation: all state returns to reset values immediately. Captured edges are lost, and no edge is flagged from the reset value of prev.
  - Exception: with EDGE_TYPE 0 or 2, a pin held high at reset release captures one rising edge after SYNC_STAGES+1 edges. This is documented behaviour.

Test Plan:
- Reset/defaults, DATA_WIDTH=16, RESET_VALUE=16'hA5A5 → out_port=A5A5, out_en=0, irq=0; read addr 0 with in_port=0 → readdata 0x0000 one cycle after read.
- Write DIR=0x00FF, DATA=0x1234, in_port=0xAB00, wait 3 clks → read addr 0 returns 0x0000AB34; out_en=0x00FF.
- OUTSET 0x000F, then OUTCLR 0x0030 starting from DATA=0x1234 → out_port 0x123F then 0x120F; reads of addr 4/5 return 0.
- EDGE_TYPE=0, mask=0x0001, in_port bit0 0→1 → edge_cap=0x0001 at SYNC_STAGES+1 clks, irq=1; a 1→0 transition leaves edge_cap unchanged; write 0x1 to addr 3 → irq=0 next cycle.
- W1C to addr 3 in the same cycle a new rising edge on bit0 is detected → edge_cap bit0 stays 1, irq stays 1.
- Assert reset_n low mid-capture with edge_cap=0x0003 and out_port=0xFFFF → all registers at reset values without waiting for a clk edge; no spurious capture with in_port=0 after release.

Source files
------------

// File: rtl/soc_system_pio_gp.sv
// General-purpose Avalon-MM PIO: per-bit direction, synchronised inputs, edge capture with
// masked level interrupt, and atomic set/clear of output bits.
module soc_system_pio_gp #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned           EDGE_TYPE   = 0,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic                  read_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_en,
  output logic                  irq
);

  localparam logic [2:0] AddrData    = 3'd0;
  localparam logic [2:0] AddrDir     = 3'd1;
  localparam logic [2:0] AddrIrqMask = 3'd2;
  localparam logic [2:0] AddrEdgeCap = 3'd3;
  localparam logic [2:0] AddrOutSet  = 3'd4;
  localparam logic [2:0] AddrOutClr  = 3'd5;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t       data_out_q, data_out_d;
  word_t       dir_q, dir_d;
  word_t       irq_mask_q, irq_mask_d;
  word_t       edge_cap_q, edge_cap_d;
  word_t       prev_q, prev_d;
  word_t       sync_q [SYNC_STAGES];
  word_t       sync_d [SYNC_STAGES];
  word_t       sync;
  word_t       edge_det;
  word_t       w1c;
  word_t       wdata;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] rd_mux;
  logic        wr_en;
  logic        rd_en;

  // Only the low DATA_WIDTH bits of the bus are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;
  assign wdata = writedata[DATA_WIDTH-1:0];

  // Input synchroniser chain; sync is the last stage.
  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sync   = sync_q[SYNC_STAGES-1];
  assign prev_d = sync;

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = sync & ~prev_q;
      1:       edge_det = ~sync & prev_q;
      default: edge_det = sync ^ prev_q;
    endcase
  end

  // Register writes.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    w1c        = '0;
    if (wr_en) begin
      case (address)
        AddrData:    data_out_d = wdata;
        AddrDir:     dir_d      = wdata;
        AddrIrqMask: irq_mask_d = wdata;
        AddrEdgeCap: w1c        = wdata;
        AddrOutSet:  data_out_d = data_out_q | wdata;
        AddrOutClr:  data_out_d = data_out_q & ~wdata;
        default:     ;
      endcase
    end
  end

  // A freshly detected edge beats a simultaneous write-1-to-clear.
  assign edge_cap_d = (edge_cap_q & ~w1c) | edge_det;

  always_comb begin
    rd_mux = '0;
    case (address)
      AddrData:    rd_mux[DATA_WIDTH-1:0] = (data_out_q & dir_q) | (sync & ~dir_q);
      AddrDir:     rd_mux[DATA_WIDTH-1:0] = dir_q;
      AddrIrqMask: rd_mux[DATA_WIDTH-1:0] = irq_mask_q;
      AddrEdgeCap: rd_mux[DATA_WIDTH-1:0] = edge_cap_q;
      default:     rd_mux = '0;
    endcase
  end

  assign readdata_d = rd_en ? rd_mux : readdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      dir_q      <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      prev_q     <= '0;
      readdata_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      prev_q     <= prev_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_out_q;
  assign out_en   = dir_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_pio_gp.sv
// Bench for soc_system_pio_gp: scoreboarded register reads plus direct pin/irq checks.
module tb_soc_system_pio_gp;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic [15:0] out_en;
  logic        irq;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic        rd_vld;

  soc_system_pio_gp #(
    .DATA_WIDTH (16),
    .RESET_VALUE(16'hA5A5),
    .EDGE_TYPE  (0),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .read_n    (read_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .out_en    (out_en),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_rd(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = addr;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  always @(posedge clk) rd_vld <= chipselect && !read_n;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", readdata, 32'hDEAD_BEEF);
      end else begin
        check_eq(tag_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rd_vld     = 1'b0;
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    read_n     = 1'b1;
    address    = '0;
    writedata  = '0;
    in_port    = '0;
    #1 reset_n = 1'b0;
    #2;
    check_eq("rst_out_port", {16'h0, out_port}, 32'h0000_A5A5);
    check_eq("rst_out_en", {16'h0, out_en}, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_readdata", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    bus_rd("rd_data_rst", 3'd0, 32'h0000_0000);

    // Mixed direction read-back.
    bus_wr(3'd1, 32'h0000_00FF);
    bus_wr(3'd0, 32'hFFFF_1234);
    in_port = 16'hAB00;
    repeat (3) @(posedge clk);
    #1;
    bus_rd("rd_data_mixed", 3'd0, 32'h0000_AB34);
    check_eq("out_en_dir", {16'h0, out_en}, 32'h0000_00FF);
    bus_rd("rd_dir", 3'd1, 32'h0000_00FF);
    repeat (2) @(posedge clk);
    #1;
    check_eq("readdata_hold", readdata, 32'h0000_00FF);
    bus_rd("rd_cap_inputs", 3'd3, 32'h0000_AB00);
    bus_wr(3'd3, 32'h0000_FFFF);
    bus_rd("rd_cap_cleared", 3'd3, 32'h0);

    // Atomic set / clear.
    bus_wr(3'd4, 32'h0000_000F);
    check_eq("outset", {16'h0, out_port}, 32'h0000_123F);
    bus_wr(3'd5, 32'h0000_0030);
    check_eq("outclr", {16'h0, out_port}, 32'h0000_120F);
    bus_rd("rd_outset", 3'd4, 32'h0);
    bus_rd("rd_outclr", 3'd5, 32'h0);
    bus_wr(3'd6, 32'h0000_FFFF);
    bus_wr(3'd7, 32'h0000_0000);
    check_eq("addr67_ignored", {16'h0, out_port}, 32'h0000_120F);
    bus_rd("rd_addr6", 3'd6, 32'h0);
    bus_rd("rd_data_setclr", 3'd0, 32'h0000_AB0F);

    // Rising-edge capture with latency, falling edges ignored.
    in_port = 16'h0000;
    repeat (4) @(posedge clk);
    bus_rd("rd_cap_no_fall", 3'd3, 32'h0);
    bus_wr(3'd2, 32'h0000_0001);
    check_eq("irq_idle", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 in_port = 16'h0001;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("irq_before_lat", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("irq_after_lat", {31'h0, irq}, 32'h1);
    in_port = 16'h0000;
    repeat (4) @(posedge clk);
    bus_rd("rd_cap_bit0", 3'd3, 32'h0000_0001);
    check_eq("irq_held", {31'h0, irq}, 32'h1);
    bus_wr(3'd3, 32'h0000_0001);
    check_eq("irq_w1c", {31'h0, irq}, 32'h0);

    // Clear coinciding with a new detected edge: the set wins.
    @(posedge clk);
    #1 in_port = 16'h0001;
    @(posedge clk);
    bus_wr(3'd3, 32'h0000_0001);
    check_eq("irq_set_wins", {31'h0, irq}, 32'h1);
    bus_rd("rd_cap_set_wins", 3'd3, 32'h0000_0001);
    bus_wr(3'd3, 32'h0000_0001);
    check_eq("irq_w1c_again", {31'h0, irq}, 32'h0);

    // Asynchronous reset in the middle of activity.
    in_port = 16'h0000;
    repeat (4) @(posedge clk);
    in_port = 16'h0003;
    repeat (4) @(posedge clk);
    in_port = 16'h0000;
    repeat (4) @(posedge clk);
    bus_wr(3'd2, 32'h0000_0003);
    bus_wr(3'd0, 32'h0000_FFFF);
    bus_rd("rd_cap_pre_rst", 3'd3, 32'h0000_0003);
    check_eq("irq_pre_rst", {31'h0, irq}, 32'h1);
    check_eq("out_pre_rst", {16'h0, out_port}, 32'h0000_FFFF);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_out", {16'h0, out_port}, 32'h0000_A5A5);
    check_eq("async_rst_en", {16'h0, out_en}, 32'h0);
    check_eq("async_rst_irq", {31'h0, irq}, 32'h0);
    check_eq("async_rst_rd", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    bus_rd("rd_cap_post_rst", 3'd3, 32'h0);
    bus_rd("rd_mask_post_rst", 3'd2, 32'h0);
    check_eq("irq_post_rst", {31'h0, irq}, 32'h0);

    repeat (3) @(posedge clk);
    check_eq("sb_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
